mem_wb_pipe_reg: RTL and testbench

- Parametrised MEM→WB pipeline register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer.
- Also produces the write-back data select (load value vs ALU result), the register-file write strobe and a forwarding tap for the hazard unit.
- Sits between the memory stage and the register-file write port.
- Replaces the fixed-width, always-loading stage register with one that can stall, flush and absorb backpressure.

---
 rtl/mem_wb_pkg.sv | 30 +++
 rtl/mem_wb_skid.sv | 89 ++++++++
 rtl/mem_wb_pipe_reg.sv | 73 +++++++
 tb/tb_mem_wb_pipe_reg.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// ============================================================================
// Module  : mem_wb_pkg
// Purpose : Shared types and default widths for the MEM->WB pipeline register.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_wb_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int PC_W       = 32;

    typedef struct packed {
        logic                  wb_en;
        logic                  mem_r_en;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     mem_read_value;
        logic [REG_ADDR_W-1:0] dest;
        logic [PC_W-1:0]       pc;
    } mem_wb_payload_t;

    // Packed payload width for arbitrary parameterisations of the stage.
    function automatic int payload_width(input int data_w, input int reg_w, input int pc_w);
        return 2 + 2 * data_w + reg_w + pc_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_skid.sv
// ============================================================================
// Module  : mem_wb_skid
// Purpose : Generic valid/ready payload register with flush; two-entry skid
//           form when MEM_WB_SKID_EN is defined, single register otherwise.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_wb_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_head_valid;
    logic [WIDTH-1:0] r_head_data;
    logic             w_head_free;
    logic             w_accept;

    assign w_head_free = !r_head_valid || out_ready;

`ifdef MEM_WB_SKID_EN
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    // Depends only on state, so WB backpressure never reaches MEM combinationally.
    assign in_ready = !r_skid_valid && !rst;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (flush) begin
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_head_free) begin
            if (r_skid_valid) begin
                r_head_valid <= 1'b1;
                r_head_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_head_valid <= 1'b1;
                r_head_data  <= in_data;
            end else begin
                r_head_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
        end
    end
`else
    assign in_ready = w_head_free && !rst;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
        end else if (flush) begin
            r_head_valid <= 1'b0;
        end else if (w_head_free) begin
            if (w_accept) begin
                r_head_valid <= 1'b1;
                r_head_data  <= in_data;
            end else begin
                r_head_valid <= 1'b0;
            end
        end
    end
`endif

    assign out_valid = r_head_valid;
    assign out_data  = r_head_data;

endmodule

`default_nettype wire

// File: rtl/mem_wb_pipe_reg.sv
// ============================================================================
// Module  : mem_wb_pipe_reg
// Purpose : MEM->WB stage register with handshake, flush, write-back mux and
//           forwarding tap. Optional skid buffer via MEM_WB_SKID_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_wb_pipe_reg #(
    parameter int DATA_W     = mem_wb_pkg::DATA_W,
    parameter int REG_ADDR_W = mem_wb_pkg::REG_ADDR_W,
    parameter int PC_W       = mem_wb_pkg::PC_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  WB_en_in,
    input  logic                  MEM_R_EN_in,
    input  logic [DATA_W-1:0]     ALU_result_in,
    input  logic [DATA_W-1:0]     MEM_read_value_in,
    input  logic [REG_ADDR_W-1:0] Dest_in,
    input  logic [PC_W-1:0]       PC_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  WB_en,
    output logic                  MEM_R_EN,
    output logic [DATA_W-1:0]     ALU_result,
    output logic [DATA_W-1:0]     MEM_read_value,
    output logic [REG_ADDR_W-1:0] Dest,
    output logic [PC_W-1:0]       PC,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  wb_we,
    output logic                  fwd_en,
    output logic [REG_ADDR_W-1:0] fwd_dest,
    output logic [DATA_W-1:0]     fwd_data
);

    import mem_wb_pkg::*;

    localparam int c_PAY_W = payload_width(DATA_W, REG_ADDR_W, PC_W);

    logic [c_PAY_W-1:0] w_in_pay;
    logic [c_PAY_W-1:0] w_head_pay;

    assign w_in_pay = {WB_en_in, MEM_R_EN_in, ALU_result_in, MEM_read_value_in, Dest_in, PC_in};

    mem_wb_skid #(
        .WIDTH (c_PAY_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_pay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_head_pay)
    );

    assign {WB_en, MEM_R_EN, ALU_result, MEM_read_value, Dest, PC} = w_head_pay;

    assign wb_data  = MEM_R_EN ? MEM_read_value : ALU_result;
    assign wb_we    = out_valid && out_ready && WB_en;
    assign fwd_en   = out_valid && WB_en;
    assign fwd_dest = Dest;
    assign fwd_data = wb_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_pipe_reg.sv
// ============================================================================
// Module  : tb_mem_wb_pipe_reg
// Purpose : Scoreboard bench; the DUT is modelled as a small FIFO (capacity 2
//           with MEM_WB_SKID_EN, else 1) that flush/reset empty.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_pipe_reg;
    import mem_wb_pkg::*;

`ifdef MEM_WB_SKID_EN
    localparam bit c_SKID = 1'b1;
`else
    localparam bit c_SKID = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic                  WB_en_in, MEM_R_EN_in, WB_en, MEM_R_EN, wb_we, fwd_en;
    logic [DATA_W-1:0]     ALU_result_in, MEM_read_value_in, ALU_result, MEM_read_value;
    logic [DATA_W-1:0]     wb_data, fwd_data;
    logic [REG_ADDR_W-1:0] Dest_in, Dest, fwd_dest;
    logic [PC_W-1:0]       PC_in, PC;

    mem_wb_pipe_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in), .ALU_result_in(ALU_result_in),
        .MEM_read_value_in(MEM_read_value_in), .Dest_in(Dest_in), .PC_in(PC_in),
        .out_valid(out_valid), .out_ready(out_ready), .WB_en(WB_en), .MEM_R_EN(MEM_R_EN),
        .ALU_result(ALU_result), .MEM_read_value(MEM_read_value), .Dest(Dest), .PC(PC),
        .wb_data(wb_data), .wb_we(wb_we), .fwd_en(fwd_en), .fwd_dest(fwd_dest),
        .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    mem_wb_payload_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the visible head against the model's oldest entry.
    always @(negedge clk) begin
        if (mon_en) begin
            mem_wb_payload_t h;
            logic            exp_ir;
            if (rst)         exp_ir = 1'b0;
            else if (c_SKID) exp_ir = (exp_q.size() < 2);
            else             exp_ir = (exp_q.size() == 0) || out_ready;
            chk("in_ready", in_ready, exp_ir);
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (!rst && exp_q.size() != 0) begin
                h = exp_q[0];
                chk("wb_en",    WB_en,          h.wb_en);
                chk("mem_r_en", MEM_R_EN,       h.mem_r_en);
                chk("alu",      ALU_result,     h.alu_result);
                chk("memval",   MEM_read_value, h.mem_read_value);
                chk("dest",     Dest,           h.dest);
                chk("pc",       PC,             h.pc);
                chk("wb_data",  wb_data,  h.mem_r_en ? h.mem_read_value : h.alu_result);
                chk("fwd_data", fwd_data, h.mem_r_en ? h.mem_read_value : h.alu_result);
                chk("fwd_dest", fwd_dest, h.dest);
                chk("fwd_en",   fwd_en,   h.wb_en);
                chk("wb_we",    wb_we,    h.wb_en & out_ready);
                if (out_ready) void'(exp_q.pop_front());
            end else if (!rst) begin
                chk("idle_wb_we",  wb_we,  1'b0);
                chk("idle_fwd_en", fwd_en, 1'b0);
            end
            if (rst || flush) exp_q.delete();
        end
    end

    // One cycle of stimulus; the accepted entry becomes an expectation.
    task automatic step(input logic r, input logic iv, input logic ordy, input logic fl,
                        input mem_wb_payload_t p);
        @(posedge clk);
        #1;
        rst = r; in_valid = iv; out_ready = ordy; flush = fl;
        {WB_en_in, MEM_R_EN_in, ALU_result_in, MEM_read_value_in, Dest_in, PC_in} = p;
        @(negedge clk);
        #2;
        if (!rst && in_valid && in_ready && !flush) exp_q.push_back(p);
    endtask

    function automatic mem_wb_payload_t mk(input logic we, input logic ld, input logic [31:0] alu,
                                           input logic [31:0] mv, input logic [4:0] d,
                                           input logic [31:0] pc);
        mem_wb_payload_t p;
        p.wb_en = we; p.mem_r_en = ld; p.alu_result = alu;
        p.mem_read_value = mv; p.dest = d; p.pc = pc;
        return p;
    endfunction

    function automatic mem_wb_payload_t rnd();
        return mk(1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom), $urandom);
    endfunction

    mem_wb_payload_t z;

    initial begin
        z = '0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        {WB_en_in, MEM_R_EN_in, ALU_result_in, MEM_read_value_in, Dest_in, PC_in} = rnd();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_in_ready",  in_ready,  1'b0);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_wb_we",     wb_we,     1'b0);
            chk("rst_fwd_en",    fwd_en,    1'b0);
            chk("rst_wb_data",   wb_data,   '0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready",  in_ready,  1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);
        #1 mon_en = 1'b1;

        // Load, ALU result, bubble
        step(0, 1, 1, 0, mk(1, 1, 32'h10, 32'hDEADBEEF, 5'd7, 32'h100));
        step(0, 1, 1, 0, mk(1, 0, 32'h10, 32'hDEADBEEF, 5'd7, 32'h104));
        step(0, 1, 1, 0, mk(0, 0, 32'h55, 32'h66, 5'd3, 32'h108));
        // Stall with back-to-back offers, then drain
        step(0, 1, 0, 0, mk(1, 0, 32'hA, 32'h0, 5'd1, 32'h200));
        step(0, 1, 0, 0, mk(1, 1, 32'hB, 32'hBB, 5'd2, 32'h204));
        step(0, 1, 0, 0, mk(1, 0, 32'hC, 32'h0, 5'd4, 32'h208));
        step(0, 0, 1, 0, z);
        step(0, 0, 1, 0, z);
        step(0, 0, 1, 0, z);
        // Fill, then flush together with a new offer
        step(0, 1, 0, 0, mk(1, 0, 32'hA1, 32'h0, 5'd1, 32'h300));
        step(0, 1, 0, 0, mk(1, 0, 32'hB1, 32'h0, 5'd2, 32'h304));
        step(0, 1, 0, 1, mk(1, 0, 32'hC1, 32'h0, 5'd5, 32'h308));
        step(0, 0, 1, 0, z);
        step(0, 0, 1, 0, z);

        // Randomised traffic with stalls, flushes and one mid-run reset
        for (int i = 0; i < 800; i++) begin
            step(i == 400, ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 24) == 0, rnd());
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, z);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
